leaky_relu_h_cache: RTL and testbench

//   Per-column cache of forward-pass pre-activation values H for the backward pass.

---
 rtl/leaky_relu_h_cache.sv | 119 +++++++++++
 tb/tb_leaky_relu_h_cache.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/leaky_relu_h_cache.sv
// FIFO cache of forward-pass pre-activations H, replayed one per gradient on the
// backward pass as a registered, aligned (valid, gradient, H) triple.
module leaky_relu_h_cache #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_in,
    input  logic          h_valid_in,
    input  logic [15:0]   h_data_in,
    input  logic          grad_valid_in,
    input  logic [15:0]   grad_data_in,
    output logic          lr_d_valid_out,
    output logic [15:0]   lr_d_data_out,
    output logic [15:0]   lr_d_H_data_out,
    output logic [AW:0]   count_out,
    output logic          full_out,
    output logic          empty_out,
    output logic          overflow_out,
    output logic          underflow_out
);

    logic [15:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          valid_q, valid_d;
    logic [15:0]   grad_q, grad_d;
    logic [15:0]   hout_q, hout_d;

    logic full, empty, pop, push;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    // Flush suppresses both operations so no flag can be set in the flush cycle.
    assign pop   = !flush_in && grad_valid_in && !empty;
    assign push  = !flush_in && h_valid_in && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        valid_d  = 1'b0;
        grad_d   = '0;
        hout_d   = '0;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (pop) begin
                valid_d  = 1'b1;
                grad_d   = grad_data_in;
                hout_d   = mem[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (grad_valid_in && !pop) begin
                udf_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (h_valid_in && !push) begin
                ovf_d = 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            valid_q  <= 1'b0;
            grad_q   <= '0;
            hout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            valid_q  <= valid_d;
            grad_q   <= grad_d;
            hout_q   <= hout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= h_data_in;
        end
    end

    assign lr_d_valid_out  = valid_q;
    assign lr_d_data_out   = grad_q;
    assign lr_d_H_data_out = hout_q;
    assign count_out       = count_q;
    assign full_out        = full;
    assign empty_out       = empty;
    assign overflow_out    = ovf_q;
    assign underflow_out   = udf_q;

endmodule

// File: tb/tb_leaky_relu_h_cache.sv
// Scoreboard bench for leaky_relu_h_cache: queue-based reference model on the
// stimulus side, independent monitor comparing every output cycle.
module tb_leaky_relu_h_cache;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fl = 1'b0, hv = 1'b0, gv = 1'b0;
    logic [15:0] hd = '0, gd = '0;
    logic        lr_d_valid_out;
    logic [15:0] lr_d_data_out, lr_d_H_data_out;
    logic [4:0]  count_out;
    logic        full_out, empty_out, overflow_out, underflow_out;

    leaky_relu_h_cache #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush_in(fl),
        .h_valid_in(hv), .h_data_in(hd),
        .grad_valid_in(gv), .grad_data_in(gd),
        .lr_d_valid_out(lr_d_valid_out), .lr_d_data_out(lr_d_data_out),
        .lr_d_H_data_out(lr_d_H_data_out), .count_out(count_out),
        .full_out(full_out), .empty_out(empty_out),
        .overflow_out(overflow_out), .underflow_out(underflow_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: contents as a plain queue, sticky flags, expected pairs.
    logic [15:0] m_q [$];
    logic [31:0] sb  [$];
    logic        m_valid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
    logic        mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        sb.delete();
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic model_step();
        int  sz;
        bit  popped;
        sz = m_q.size();
        m_valid = 1'b0;
        if (fl) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            popped = gv && (sz > 0);
            if (popped) begin
                sb.push_back({gd, m_q.pop_front()});
                m_valid = 1'b1;
            end else if (gv) begin
                m_udf = 1'b1;
            end
            if (hv) begin
                if (sz < DEPTH || popped) m_q.push_back(hd);
                else m_ovf = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the active edge.
    task automatic cycle(input logic h_v, input logic [15:0] h_d,
                         input logic g_v, input logic [15:0] g_d, input logic f);
        hv = h_v; hd = h_d; gv = g_v; gd = g_d; fl = f;
        @(posedge clk);
        model_step();
        #1;
        hv = 1'b0; gv = 1'b0; fl = 1'b0; hd = '0; gd = '0;
    endtask

    task automatic push(input logic [15:0] h);
        cycle(1'b1, h, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic grad(input logic [15:0] g);
        cycle(1'b0, 16'h0, 1'b1, g, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic flush();
        cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    endtask

    // Asserts rst between edges and checks outputs before any clock edge arrives.
    task automatic async_reset();
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_valid", lr_d_valid_out, 0);
        check("rst_grad",  lr_d_data_out, 0);
        check("rst_H",     lr_d_H_data_out, 0);
        check("rst_count", count_out, 0);
        check("rst_empty", empty_out, 1);
        check("rst_full",  full_out, 0);
        check("rst_ovf",   overflow_out, 0);
        check("rst_udf",   underflow_out, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    function automatic logic [15:0] lrelu_d(input logic [15:0] g, input logic [15:0] h);
        logic signed [31:0] p;
        if ($signed(h) > 0) return g;
        p = $signed(g) * 32'sh0019;
        return p[23:8];
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            logic [31:0] e;
            check("valid", lr_d_valid_out, m_valid);
            if (m_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: got empty expected entry at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("grad_out", lr_d_data_out, e[31:16]);
                    check("H_out", lr_d_H_data_out, e[15:0]);
                end
            end else begin
                check("grad_idle", lr_d_data_out, 0);
                check("H_idle", lr_d_H_data_out, 0);
            end
            check("count", count_out, m_q.size());
            check("full",  full_out, m_q.size() == DEPTH);
            check("empty", empty_out, m_q.size() == 0);
            check("ovf",   overflow_out, m_ovf);
            check("udf",   underflow_out, m_udf);
        end
    end

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        check("init_count", count_out, 0);
        check("init_empty", empty_out, 1);
        check("init_full",  full_out, 0);
        check("init_valid", lr_d_valid_out, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic pairing with idle cycles between gradients
        push(16'h0100); push(16'hFF00); push(16'h0080);
        grad(16'h0200); idle(); grad(16'h0300); idle(); grad(16'h0400); idle();

        // Fill, overflow, drain in order
        for (int unsigned i = 0; i < DEPTH; i++) push(16'(16'h1000 + i));
        push(16'hDEAD);
        for (int unsigned i = 0; i < DEPTH; i++) grad(16'(16'h0A00 + i));
        idle();

        // Full with simultaneous push and pop; incoming H comes out last
        flush();
        for (int unsigned i = 0; i < DEPTH; i++) push(16'(16'h2000 + i));
        cycle(1'b1, 16'h7FFF, 1'b1, 16'h0555, 1'b0);
        for (int unsigned i = 0; i < DEPTH; i++) grad(16'(16'h0B00 + i));
        idle();

        // Empty with simultaneous push and gradient: no bypass
        flush();
        cycle(1'b1, 16'h0010, 1'b1, 16'h0777, 1'b0);
        grad(16'h0888);
        idle();

        // Flush wins over a same-cycle gradient and push
        for (int unsigned i = 0; i < 5; i++) push(16'(16'h3000 + i));
        cycle(1'b1, 16'h4444, 1'b1, 16'h0999, 1'b1);
        idle();

        // Asynchronous reset mid-stream
        for (int unsigned i = 0; i < 4; i++) push(16'(16'h5000 + i));
        grad(16'h0123);
        async_reset();
        idle();

        // Derivative stage chained on the aligned outputs
        push(16'h0100); push(16'hFF00);
        grad(16'h0100);
        check("deriv_pos", lrelu_d(lr_d_data_out, lr_d_H_data_out), 16'h0100);
        grad(16'h0100);
        check("deriv_neg", lrelu_d(lr_d_data_out, lr_d_H_data_out), 16'h0019);
        idle();

        // Randomized traffic alternating fill-biased and drain-biased phases
        for (int unsigned i = 0; i < 800; i++) begin
            bit fillp;
            logic h_v, g_v, f;
            fillp = ((i / 60) % 2) == 0;
            h_v = $urandom_range(99) < (fillp ? 80 : 25);
            g_v = $urandom_range(99) < (fillp ? 30 : 75);
            f   = $urandom_range(99) < 2;
            cycle(h_v, 16'($urandom), g_v, 16'($urandom), f);
            if (i == 400) async_reset();
        end
        idle();

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
